pfft_mul_share_arb: RTL and testbench
=====================================

Name: pfft_mul_share_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one external 59x6 unsigned combinational multiplier among NUM_REQ posit-FFT requesters (e.g. mantissa-scaling units in the butterfly stages).
- Registers the winning operands, drives them onto the multiplier, and registers the product.
- Returns the product with the requester's ID on a single valid/ready response channel.
- Sustains one multiply per cycle when there is no backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- A_WIDTH, 59, operand A width
- B_WIDTH, 6, operand B width
- P_WIDTH, 65, product width; must equal A_WIDTH+B_WIDTH
- ID_WIDTH, 2, requester ID width; must equal clog2(NUM_REQ)

Ports:
- ap_clk  in  1  clock; all state on rising edge
- ap_rst_n  in  1  synchronous reset, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit high
- req_a  in  NUM_REQ*A_WIDTH  operand A; requester i occupies slice [i*A_WIDTH +: A_WIDTH]
- req_b  in  NUM_REQ*B_WIDTH  operand B; same packing
- mul_din0  out  A_WIDTH  operand A to the shared multiplier
- mul_din1  out  B_WIDTH  operand B to the shared multiplier
- mul_dout  in  P_WIDTH  product from the shared multiplier; combinational, unsigned
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_WIDTH  requester index of the response
- rsp_data  out  P_WIDTH  product
- busy  out  1  high if any req_valid, op_valid or rsp_valid is high

Behaviour:
- Pipeline is two register stages:
  - S1 (op_valid, op_id, op_a, op_b): drives mul_din0/mul_din1.
  - S2 (rsp_valid, rsp_id, rsp_data): captures mul_dout.
- Stall rules:
  - s2_free = !rsp_valid | rsp_ready.
  - s1_adv = op_valid & s2_free.
  - s1_free = !op_valid | s1_adv.
- Arbitration:
  - If s1_free, grant the first i with req_valid[i], searching from (last+1) mod NUM_REQ upward with wrap.
  - req_ready = onehot(grant) & {NUM_REQ{s1_free}}. req_ready is combinational from req_valid, state and rsp_ready.
  - A handshake at edge E loads S1 and sets last = granted index.
  - last resets to NUM_REQ-1, so requester 0 wins first.
  - last updates only on a granted handshake.
- S1 update: on s1_adv with no new grant, op_valid clears.
- S2 update:
  - On s1_adv, S2 loads {op_id, mul_dout} and rsp_valid = 1.
  - Else, if rsp_ready, rsp_valid clears.
  - Else S2 holds; rsp_id and rsp_data stay stable while rsp_valid is high and rsp_ready is low.
- Latency: request accepted in cycle t → operands on mul_din in t+1 → rsp_valid in t+2, if rsp_ready was high.
- Throughput: 1 response per cycle with rsp_ready held high.
- mul_din0 and mul_din1 are forced to 0 when op_valid = 0.
- Arithmetic: rsp_data = zero-extended unsigned A*B, exact in P_WIDTH bits; no truncation or saturation.
- Backpressure: with rsp_ready low, S1 and S2 both fill (2 results held), then every req_ready stays low. No result is lost or duplicated.
- Simultaneous events: S2 draining and S1 advancing on the same edge is legal. A new grant on that same edge also loads S1 (full throughput).
- Reset (ap_rst_n low at an edge), including mid-operation:
  - op_valid = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, op_a = 0, op_b = 0, op_id = 0, last = NUM_REQ-1.
  - In-flight products are discarded; no response is emitted for them.
  - While ap_rst_n is low, req_ready = 0.

Test Plan:
- Single request, rsp_ready = 1: req_valid[2] with A = 1000, B = 7 in cycle t → req_ready[2] = 1 in t; mul_din0 = 1000 and mul_din1 = 7 in t+1; rsp_valid = 1, rsp_id = 2, rsp_data = 7000 in t+2.
- Contention: all 4 req_valid held high, each with A = i+1, B = 2, after reset → grants in order 0,1,2,3,0…; responses (id, data) = (0,2), (1,4), (2,6), (3,8), one per cycle.
- Backpressure: stream from requester 1 with rsp_ready = 0 for 5 cycles → exactly 2 accepted, then req_ready = 0; rsp_data held stable. On release, both results drain in order, then streaming resumes.
- Width corners: A = 2^59-1, B = 63 → rsp_data = 0x1_F7FF_FFFF_FFFF_FFC1. A = 0, B = 63 → 0. A = 2^59-1, B = 1 → 2^59-1.
- Fairness: requester 0 continuously valid, requester 3 asserts once → requester 3 is granted within 2 cycles; requester 0 is never granted twice in a row while requester 3 is pending.
- Reset mid-flight: ap_rst_n low for 1 edge while S1 and S2 are both valid → rsp_valid = 0 and busy follows only req_valid; the next grant goes to requester 0; no stale response appears.

Source files
------------

// File: rtl/pfft_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : pfft_mul_share_arb
// Purpose  : Round-robin arbiter/sequencer that time-shares one external
//            unsigned combinational multiplier (A_WIDTH x B_WIDTH) among
//            NUM_REQ posit-FFT requesters. Winning operands are registered
//            (S1), driven to the multiplier, and the product is registered
//            (S2) and returned with the requester ID on a valid/ready channel.
//            One multiply per cycle is sustained without backpressure.
// Ports    :
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (ready one-hot)
//   req_a/req_b             packed operands, requester i at [i*W +: W]
//   mul_din0/mul_din1       operands to the shared multiplier (0 when idle)
//   mul_dout                product from the shared multiplier
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/rsp_data         requester index and product of the response
//   busy                    any request pending or any stage occupied
// Revision : 1.0 - initial release
// ============================================================================
module pfft_mul_share_arb #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 59,
  parameter int B_WIDTH  = 6,
  parameter int P_WIDTH  = 65,
  parameter int ID_WIDTH = 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
  output logic [A_WIDTH-1:0]          mul_din0,
  output logic [B_WIDTH-1:0]          mul_din1,
  input  logic [P_WIDTH-1:0]          mul_dout,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_WIDTH-1:0]         rsp_id,
  output logic [P_WIDTH-1:0]          rsp_data,
  output logic                        busy
);

  localparam logic [ID_WIDTH-1:0] c_last_rst = ID_WIDTH'(NUM_REQ - 1);

  // S1: operand stage
  logic                r_op_valid;
  logic [ID_WIDTH-1:0] r_op_id;
  logic [A_WIDTH-1:0]  r_op_a;
  logic [B_WIDTH-1:0]  r_op_b;

  // S2: response stage
  logic                r_rsp_valid;
  logic [ID_WIDTH-1:0] r_rsp_id;
  logic [P_WIDTH-1:0]  r_rsp_data;

  // index of the most recent winner; search starts one past it
  logic [ID_WIDTH-1:0] r_last;

  logic                w_s2_free;
  logic                w_s1_adv;
  logic                w_s1_free;
  logic                w_found;
  logic [ID_WIDTH-1:0] w_gnt_id;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic                w_take;
  logic [A_WIDTH-1:0]  w_sel_a;
  logic [B_WIDTH-1:0]  w_sel_b;

  assign w_s2_free = !r_rsp_valid || rsp_ready;
  assign w_s1_adv  = r_op_valid && w_s2_free;
  assign w_s1_free = !r_op_valid || w_s1_adv;

  // Rotating priority search: first valid requester after r_last, with wrap.
  always_comb begin : p_arb
    int w_idx;
    w_idx    = 0;
    w_found  = 1'b0;
    w_gnt_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = ID_WIDTH'(w_idx);
      end
    end
  end

  // Reset gating keeps every grant low while ap_rst_n is asserted, so no
  // request is consumed on an edge whose state update is being discarded.
  always_comb begin
    w_req_ready = '0;
    if (w_found && w_s1_free && ap_rst_n) begin
      w_req_ready = NUM_REQ'(1) << w_gnt_id;
    end
  end

  assign w_take    = |w_req_ready;
  assign req_ready = w_req_ready;

  assign w_sel_a = req_a[int'(w_gnt_id)*A_WIDTH +: A_WIDTH];
  assign w_sel_b = req_b[int'(w_gnt_id)*B_WIDTH +: B_WIDTH];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_op_valid  <= 1'b0;
      r_op_id     <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_last      <= c_last_rst;
    end else begin
      // A new grant refills S1 even on the edge its old content advances.
      if (w_take) begin
        r_op_valid <= 1'b1;
        r_op_id    <= w_gnt_id;
        r_op_a     <= w_sel_a;
        r_op_b     <= w_sel_b;
        r_last     <= w_gnt_id;
      end else if (w_s1_adv) begin
        r_op_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_op_id;
        r_rsp_data  <= mul_dout;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Idle operands are zeroed so the shared multiplier sees no stale values.
  assign mul_din0  = r_op_valid ? r_op_a : '0;
  assign mul_din1  = r_op_valid ? r_op_b : '0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (|req_valid) || r_op_valid || r_rsp_valid;

endmodule
`default_nettype wire

// File: tb/tb_pfft_mul_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pfft_mul_share_arb
// Purpose  : Self-checking bench for pfft_mul_share_arb with a behavioural
//            shared multiplier and a scoreboard of expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pfft_mul_share_arb;

  localparam int NUM_REQ  = 4;
  localparam int A_WIDTH  = 59;
  localparam int B_WIDTH  = 6;
  localparam int P_WIDTH  = 65;
  localparam int ID_WIDTH = 2;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [P_WIDTH-1:0]  data;
  } exp_t;

  logic                       ap_clk;
  logic                       ap_rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic [A_WIDTH-1:0]         mul_din0;
  logic [B_WIDTH-1:0]         mul_din1;
  logic [P_WIDTH-1:0]         mul_dout;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_WIDTH-1:0]        rsp_id;
  logic [P_WIDTH-1:0]         rsp_data;
  logic                       busy;

  logic [A_WIDTH-1:0] av [NUM_REQ];
  logic [B_WIDTH-1:0] bv [NUM_REQ];

  exp_t sb[$];
  int   n_chk;
  int   n_fail;
  int   n_acc;
  logic                held_v;
  logic [ID_WIDTH-1:0] held_id;
  logic [P_WIDTH-1:0]  held_data;

  pfft_mul_share_arb #(
    .NUM_REQ (NUM_REQ),
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH),
    .ID_WIDTH(ID_WIDTH)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  // external shared multiplier
  assign mul_dout = P_WIDTH'(mul_din0) * P_WIDTH'(mul_din1);

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*A_WIDTH +: A_WIDTH] = av[i];
      req_b[i*B_WIDTH +: B_WIDTH] = bv[i];
    end
  end

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  // Monitor on the falling edge: inputs change only just after rising edges.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      chk("rst_req_ready", 80'(req_ready), 80'(0));
      sb.delete();
      held_v = 1'b0;
    end else begin
      chk("ready_onehot0", 80'($onehot0(req_ready)), 80'(1));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: ID_WIDTH'(i), data: P_WIDTH'(av[i]) * P_WIDTH'(bv[i])});
          n_acc++;
        end
      end
      if (held_v) begin
        chk("hold_valid", 80'(rsp_valid), 80'(1));
        chk("hold_data", 80'({rsp_id, rsp_data}), 80'({held_id, held_data}));
      end
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", 80'(sb.size() != 0), 80'(1));
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_rsp_id", 80'(rsp_id), 80'(e.id));
          chk("sb_rsp_data", 80'(rsp_data), 80'(e.data));
        end
      end
      held_v    = rsp_valid && !rsp_ready;
      held_id   = rsp_id;
      held_data = rsp_data;
    end
  end

  task automatic drain(input string tag);
    for (int k = 0; k < 30 && (sb.size() != 0 || rsp_valid); k++) cyc(1);
    chk({tag, "_sb_empty"}, 80'(sb.size()), 80'(0));
    chk({tag, "_rsp_idle"}, 80'(rsp_valid), 80'(0));
  endtask

  task automatic single(input string tag, input int id, input logic [A_WIDTH-1:0] a,
                        input logic [B_WIDTH-1:0] b, input logic [P_WIDTH-1:0] e);
    av[id]    = a;
    bv[id]    = b;
    req_valid = NUM_REQ'(1 << id);
    #1;
    chk({tag, "_ready"}, 80'(req_ready), 80'(1 << id));
    cyc(1);
    req_valid = '0;
    chk({tag, "_din0"}, 80'(mul_din0), 80'(a));
    chk({tag, "_din1"}, 80'(mul_din1), 80'(b));
    cyc(1);
    chk({tag, "_valid"}, 80'(rsp_valid), 80'(1));
    chk({tag, "_id"}, 80'(rsp_id), 80'(id));
    chk({tag, "_data"}, 80'(rsp_data), 80'(e));
    cyc(1);
  endtask

  initial begin
    bit got;
    n_chk = 0; n_fail = 0; n_acc = 0; held_v = 1'b0;
    held_id = '0; held_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin av[i] = '0; bv[i] = '0; end
    ap_rst_n  = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    cyc(2);
    req_valid = '0;
    ap_rst_n  = 1'b1;
    #1;
    chk("reset_rsp_valid", 80'(rsp_valid), 80'(0));
    chk("reset_rsp_id", 80'(rsp_id), 80'(0));
    chk("reset_rsp_data", 80'(rsp_data), 80'(0));
    chk("reset_din0", 80'(mul_din0), 80'(0));
    chk("reset_din1", 80'(mul_din1), 80'(0));
    chk("reset_busy", 80'(busy), 80'(0));

    // single request through requester 2
    single("single", 2, 59'd1000, 6'd7, 65'd7000);
    drain("single");

    // contention after a fresh reset: strict rotation 0,1,2,3,...
    ap_rst_n = 1'b0;
    cyc(1);
    ap_rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin av[i] = A_WIDTH'(i + 1); bv[i] = 6'd2; end
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", 80'(req_ready), 80'(1 << (k % 4)));
      if (k >= 2) begin
        chk("rr_rsp_valid", 80'(rsp_valid), 80'(1));
        chk("rr_rsp_id", 80'(rsp_id), 80'((k - 2) % 4));
        chk("rr_rsp_data", 80'(rsp_data), 80'(2 * ((k - 2) % 4 + 1)));
      end
      cyc(1);
    end
    req_valid = '0;
    drain("rr");

    // backpressure: requester 1 streams while the consumer stalls 5 cycles
    begin
      int acc0;
      acc0      = n_acc;
      av[1]     = 59'd5;
      bv[1]     = 6'd3;
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      #1;
      chk("bp_ready_t0", 80'(req_ready), 80'(4'b0010));
      cyc(1);
      av[1] = 59'd6;
      #1;
      chk("bp_ready_t1", 80'(req_ready), 80'(4'b0010));
      cyc(1);
      chk("bp_ready_full", 80'(req_ready), 80'(0));
      chk("bp_rsp_valid", 80'(rsp_valid), 80'(1));
      chk("bp_rsp_data", 80'(rsp_data), 80'(15));
      cyc(2);
      chk("bp_ready_held", 80'(req_ready), 80'(0));
      chk("bp_data_held", 80'(rsp_data), 80'(15));
      chk("bp_din0_held", 80'(mul_din0), 80'(6));
      chk("bp_accepts", 80'(n_acc - acc0), 80'(2));
      cyc(1);
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 80'(req_ready), 80'(4'b0010));
      chk("bp_release_data", 80'(rsp_data), 80'(15));
      cyc(1);
      chk("bp_second_valid", 80'(rsp_valid), 80'(1));
      chk("bp_second_data", 80'(rsp_data), 80'(18));
      cyc(1);
      chk("bp_stream_valid", 80'(rsp_valid), 80'(1));
      chk("bp_stream_data", 80'(rsp_data), 80'(18));
      req_valid = '0;
      drain("bp");
    end

    // width corners
    single("max_x63", 0, {A_WIDTH{1'b1}}, 6'd63, 65'h1_F7FF_FFFF_FFFF_FFC1);
    single("zero_x63", 0, 59'd0, 6'd63, 65'd0);
    single("max_x1", 0, {A_WIDTH{1'b1}}, 6'd1, {6'd0, {A_WIDTH{1'b1}}});
    drain("corners");

    // fairness: requester 0 hogs, requester 3 asserts once
    av[0] = 59'd11; bv[0] = 6'd5; av[3] = 59'd13; bv[3] = 6'd4;
    req_valid = 4'b0001;
    cyc(3);
    req_valid = 4'b1001;
    #1;
    got = 1'b0;
    for (int k = 0; k < 2 && !got; k++) begin
      if (req_ready == 4'b1000) got = 1'b1;
      else cyc(1);
    end
    chk("fair_r3_granted", 80'(got), 80'(1));
    cyc(1);
    req_valid = 4'b0001;
    #1;
    chk("fair_r0_after", 80'(req_ready), 80'(4'b0001));
    cyc(1);
    req_valid = '0;
    drain("fair");

    // reset while both stages are full
    av[0] = 59'd9; bv[0] = 6'd9;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    cyc(2);
    chk("mid_rsp_valid", 80'(rsp_valid), 80'(1));
    chk("mid_busy", 80'(busy), 80'(1));
    ap_rst_n  = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc(1);
    ap_rst_n = 1'b1;
    #1;
    chk("mid_after_rsp_valid", 80'(rsp_valid), 80'(0));
    chk("mid_after_busy", 80'(busy), 80'(0));
    chk("mid_after_din0", 80'(mul_din0), 80'(0));
    av[1] = 59'd2; bv[1] = 6'd2;
    req_valid = 4'b0011;
    #1;
    chk("mid_next_grant", 80'(req_ready), 80'(4'b0001));
    chk("mid_busy_req", 80'(busy), 80'(1));
    cyc(1);
    req_valid = '0;
    drain("mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
